sdrc_wb_arbiter: RTL and testbench

//  N-master Wishbone arbiter placed in front of the sdrc_top Wishbone slave port. Lets several

---
 rtl/sdrc_arb_pkg.sv | 25 ++
 rtl/sdrc_rr_picker.sv | 28 ++
 rtl/sdrc_wb_arbiter.sv | 144 ++++++++++++++
 tb/tb_sdrc_wb_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdrc_arb_pkg.sv
// Shared types and helpers for the SDRAM-controller Wishbone arbiter.
// Index width covers the largest supported master count.
package sdrc_arb_pkg;

    localparam int ARB_MAX_NM = 8;
    localparam int ARB_IDX_W  = 3;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_ERR
    } arb_state_t;

    function automatic logic [ARB_IDX_W-1:0] onehot2idx(input logic [ARB_MAX_NM-1:0] oh);
        logic [ARB_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < ARB_MAX_NM; i++) begin
            if (oh[i]) begin
                idx = idx | ARB_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/sdrc_rr_picker.sv
// Round-robin picker: first requester strictly after the last winner, wrapping.
// Purely combinational, no backpressure of its own.
module sdrc_rr_picker
    import sdrc_arb_pkg::*;
#(
    parameter int NM = 4
) (
    input  logic [NM-1:0]        i_req,
    input  logic [ARB_IDX_W-1:0] i_last,
    output logic [NM-1:0]        o_gnt,
    output logic                 o_vld
);

    always_comb begin
        o_gnt = '0;
        o_vld = 1'b0;
        // offset 1..NM so the previous winner is considered last
        for (int i = 1; i <= NM; i++) begin
            for (int j = 0; j < NM; j++) begin
                if (!o_vld && i_req[j] && (j == ((int'(i_last) + i) % NM))) begin
                    o_gnt[j] = 1'b1;
                    o_vld    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sdrc_wb_arbiter.sv
// N-master round-robin Wishbone arbiter in front of sdrc_top; grant held for a whole cyc.
// One cycle from cyc to slave cyc, one dead cycle between owners; stall watchdog raises err.
module sdrc_wb_arbiter
    import sdrc_arb_pkg::*;
#(
    parameter int NM    = 4,
    parameter int DW    = 32,
    parameter int AW    = 26,
    parameter int TMO_W = 10
) (
    input  logic                 sys_clk,
    input  logic                 RESETN,
    input  logic [NM-1:0]        m_cyc_i,
    input  logic [NM-1:0]        m_stb_i,
    input  logic [NM-1:0]        m_we_i,
    input  logic [NM*AW-1:0]     m_adr_i,
    input  logic [NM*DW/8-1:0]   m_sel_i,
    input  logic [NM*DW-1:0]     m_dat_i,
    output logic [DW-1:0]        m_dat_o,
    output logic [NM-1:0]        m_ack_o,
    output logic [NM-1:0]        m_err_o,
    output logic                 s_cyc_o,
    output logic                 s_stb_o,
    output logic                 s_we_o,
    output logic [AW-1:0]        s_adr_o,
    output logic [DW/8-1:0]      s_sel_o,
    output logic [DW-1:0]        s_dat_o,
    input  logic [DW-1:0]        s_dat_i,
    input  logic                 s_ack_i,
    output logic [NM-1:0]        gnt_o
);

    localparam int SW = DW / 8;
    localparam logic [TMO_W-1:0] WDOG_MAX  = '1;
    localparam logic [TMO_W-1:0] WDOG_LAST = WDOG_MAX - TMO_W'(1);

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    logic [NM-1:0]        r_gnt;
    logic [ARB_IDX_W-1:0] r_last;
    logic [TMO_W-1:0]     r_wdog;
    logic [NM-1:0]        w_pick;
    logic                 w_pick_vld;
    logic                 w_cyc_g;
    logic                 w_stall_tmo;
    logic [ARB_IDX_W-1:0] w_gnt_idx;

    sdrc_rr_picker #(.NM(NM)) u_picker (
        .i_req  (m_cyc_i),
        .i_last (r_last),
        .o_gnt  (w_pick),
        .o_vld  (w_pick_vld)
    );

    assign w_cyc_g     = |(r_gnt & m_cyc_i);
    assign w_gnt_idx   = onehot2idx(ARB_MAX_NM'(r_gnt));
    // the stall that would push the counter to its max is the timeout; an ack in that cycle wins
    assign w_stall_tmo = s_stb_o & ~s_ack_i & (r_wdog == WDOG_LAST);
    assign gnt_o       = r_gnt;
    assign m_dat_o     = s_dat_i;

    always_ff @(posedge sys_clk) begin
        if (!RESETN) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE:  if (w_pick_vld) w_state_nxt = ARB_GRANT;
            ARB_GRANT: begin
                if (!w_cyc_g) begin
                    w_state_nxt = ARB_IDLE;
                end else if (w_stall_tmo) begin
                    w_state_nxt = ARB_ERR;
                end
            end
            ARB_ERR:   w_state_nxt = ARB_IDLE;
            default:   w_state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_sel_o = '0;
        s_dat_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        if (r_state == ARB_GRANT) begin
            for (int k = 0; k < NM; k++) begin
                if (r_gnt[k]) begin
                    s_cyc_o = m_cyc_i[k];
                    s_stb_o = m_stb_i[k];
                    s_we_o  = m_we_i[k];
                    s_adr_o = m_adr_i[k*AW +: AW];
                    s_sel_o = m_sel_i[k*SW +: SW];
                    s_dat_o = m_dat_i[k*DW +: DW];
                end
            end
            m_ack_o = r_gnt & m_stb_i & {NM{s_ack_i}};
        end else if (r_state == ARB_ERR) begin
            m_err_o = r_gnt;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!RESETN) begin
            r_gnt  <= '0;
            r_last <= ARB_IDX_W'(NM - 1);
        end else begin
            case (r_state)
                ARB_IDLE:  r_gnt <= w_pick;
                ARB_GRANT: begin
                    if (!w_cyc_g) begin
                        r_gnt  <= '0;
                        r_last <= w_gnt_idx;
                    end
                end
                ARB_ERR: begin
                    r_gnt  <= '0;
                    r_last <= w_gnt_idx;
                end
                default:   r_gnt <= '0;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!RESETN) begin
            r_wdog <= '0;
        end else if (s_ack_i || !s_stb_o) begin
            r_wdog <= '0;
        end else if (r_wdog != WDOG_MAX) begin
            r_wdog <= r_wdog + 1'b1;
        end
    end

endmodule

// File: tb/tb_sdrc_wb_arbiter.sv
// Directed bench for sdrc_wb_arbiter: single write/read, round-robin order, burst hold,
// watchdog timeout, mid-burst reset, and ack coinciding with the timeout cycle.
module tb_sdrc_wb_arbiter;

    localparam int NM    = 4;
    localparam int DW    = 32;
    localparam int AW    = 26;
    localparam int TMO_W = 4;

    logic                 sys_clk;
    logic                 RESETN;
    logic [NM-1:0]        m_cyc;
    logic [NM-1:0]        m_stb;
    logic [NM-1:0]        m_we;
    logic [NM*AW-1:0]     m_adr;
    logic [NM*DW/8-1:0]   m_sel;
    logic [NM*DW-1:0]     m_dat;
    logic [DW-1:0]        m_dat_o;
    logic [NM-1:0]        m_ack_o;
    logic [NM-1:0]        m_err_o;
    logic                 s_cyc_o;
    logic                 s_stb_o;
    logic                 s_we_o;
    logic [AW-1:0]        s_adr_o;
    logic [DW/8-1:0]      s_sel_o;
    logic [DW-1:0]        s_dat_o;
    logic [DW-1:0]        s_dat_i;
    logic                 s_ack_i;
    logic [NM-1:0]        gnt_o;

    logic                 ack_auto;
    logic                 ack_force;
    logic [DW-1:0]        mem [0:255];

    int n_chk;
    int n_fail;

    sdrc_wb_arbiter #(.NM(NM), .DW(DW), .AW(AW), .TMO_W(TMO_W)) dut (
        .sys_clk (sys_clk),
        .RESETN  (RESETN),
        .m_cyc_i (m_cyc),
        .m_stb_i (m_stb),
        .m_we_i  (m_we),
        .m_adr_i (m_adr),
        .m_sel_i (m_sel),
        .m_dat_i (m_dat),
        .m_dat_o (m_dat_o),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_we_o  (s_we_o),
        .s_adr_o (s_adr_o),
        .s_sel_o (s_sel_o),
        .s_dat_o (s_dat_o),
        .s_dat_i (s_dat_i),
        .s_ack_i (s_ack_i),
        .gnt_o   (gnt_o)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // zero-wait SDRAM stand-in: acks every strobe unless the bench takes control of ack
    assign s_ack_i = ack_auto ? (s_cyc_o & s_stb_o) : ack_force;
    assign s_dat_i = mem[s_adr_o[9:2]];

    always @(posedge sys_clk) begin
        if (s_cyc_o && s_stb_o && s_we_o && s_ack_i) begin
            for (int b = 0; b < DW/8; b++) begin
                if (s_sel_o[b]) mem[s_adr_o[9:2]][b*8 +: 8] <= s_dat_o[b*8 +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic set_m(input int k, input logic cyc, input logic stb, input logic we,
                         input logic [AW-1:0] adr, input logic [DW-1:0] dat, input logic [3:0] sel);
        m_cyc[k]           = cyc;
        m_stb[k]           = stb;
        m_we[k]            = we;
        m_adr[k*AW +: AW]  = adr;
        m_dat[k*DW +: DW]  = dat;
        m_sel[k*4 +: 4]    = sel;
    endtask

    task automatic do_reset();
        RESETN = 1'b0;
        tick();
        RESETN = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    logic [3:0] exp_g [5];
    int         exp_k [5];

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        RESETN    = 1'b0;
        m_cyc     = '0;
        m_stb     = '0;
        m_we      = '0;
        m_adr     = '0;
        m_sel     = '0;
        m_dat     = '0;
        ack_auto  = 1'b1;
        ack_force = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_k = '{0, 1, 2, 3, 0};

        tick();
        tick();
        chk("rst_gnt",   gnt_o,   0);
        chk("rst_s_cyc", s_cyc_o, 0);
        chk("rst_s_stb", s_stb_o, 0);
        chk("rst_ack",   m_ack_o, 0);
        chk("rst_err",   m_err_o, 0);
        RESETN = 1'b1;
        tick();

        // 1: single write then read-back by master 0
        set_m(0, 1'b1, 1'b1, 1'b1, 26'h0000100, 32'hA5A5A5A5, 4'hF);
        #1;
        chk("t1_s_cyc_pre", s_cyc_o, 0);
        tick();
        chk("t1_gnt",   gnt_o,   4'b0001);
        chk("t1_s_cyc", s_cyc_o, 1);
        chk("t1_s_we",  s_we_o,  1);
        chk("t1_s_adr", s_adr_o, 26'h0000100);
        chk("t1_s_dat", s_dat_o, 32'hA5A5A5A5);
        chk("t1_s_sel", s_sel_o, 4'hF);
        chk("t1_ack",   m_ack_o, 4'b0001);
        tick();
        set_m(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        tick();
        chk("t1_gnt_rel", gnt_o, 0);
        set_m(0, 1'b1, 1'b1, 1'b0, 26'h0000100, '0, 4'hF);
        tick();
        chk("t1_rd_dat", m_dat_o, 32'hA5A5A5A5);
        chk("t1_rd_ack", m_ack_o, 4'b0001);
        set_m(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        tick();
        tick();

        // 2: all four request straight out of reset
        do_reset();
        m_cyc = 4'b1111;
        m_stb = 4'b1111;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t2_gnt", gnt_o,   exp_g[i]);
            chk("t2_ack", m_ack_o, exp_g[i]);
            m_cyc[exp_k[i]] = 1'b0;
            m_stb[exp_k[i]] = 1'b0;
            tick();
            chk("t2_dead", gnt_o, 0);
            if (i < 4) begin
                m_cyc[exp_k[i]] = 1'b1;
                m_stb[exp_k[i]] = 1'b1;
            end else begin
                m_cyc = '0;
                m_stb = '0;
            end
            tick();
        end

        // 3: master 2 burst of 8 while master 1 waits
        set_m(2, 1'b1, 1'b1, 1'b1, 26'h0000200, 32'h12345678, 4'hF);
        tick();
        set_m(1, 1'b1, 1'b1, 1'b0, 26'h0000300, '0, 4'hF);
        for (int b = 0; b < 8; b++) begin
            chk("t3_gnt_hold", gnt_o,   4'b0100);
            chk("t3_ack",      m_ack_o, 4'b0100);
            tick();
        end
        set_m(2, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        #1;
        chk("t3_gnt_last", gnt_o,   4'b0100);
        chk("t3_no_ack",   m_ack_o, 0);
        tick();
        chk("t3_dead", gnt_o, 0);
        tick();
        chk("t3_m1", gnt_o, 4'b0010);
        set_m(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        tick();
        tick();

        // 4: slave never acks, master 3 times out, master 0 follows
        ack_auto  = 1'b0;
        ack_force = 1'b0;
        set_m(3, 1'b1, 1'b1, 1'b0, 26'h0000040, '0, 4'hF);
        set_m(0, 1'b1, 1'b1, 1'b0, 26'h0000080, '0, 4'hF);
        tick();
        chk("t4_gnt", gnt_o, 4'b1000);
        for (int i = 0; i < 15; i++) begin
            chk("t4_no_err", m_err_o, 0);
            tick();
        end
        chk("t4_err",   m_err_o, 4'b1000);
        chk("t4_s_cyc", s_cyc_o, 0);
        chk("t4_s_stb", s_stb_o, 0);
        ack_force = 1'b1;
        #1;
        chk("t4_ack_ignored", m_ack_o, 0);
        ack_force = 1'b0;
        set_m(3, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        tick();
        chk("t4_err_once", m_err_o, 0);
        chk("t4_dead",     gnt_o,   0);
        tick();
        chk("t4_next", gnt_o, 4'b0001);

        // 6: ack lands on the timeout cycle, then a full fresh timeout is needed
        for (int i = 0; i < 14; i++) begin
            chk("t6_no_err", m_err_o, 0);
            tick();
        end
        ack_force = 1'b1;
        #1;
        chk("t6_ack", m_ack_o, 4'b0001);
        chk("t6_err", m_err_o, 0);
        tick();
        ack_force = 1'b0;
        chk("t6_still_gnt", gnt_o,   4'b0001);
        chk("t6_err_after", m_err_o, 0);
        for (int i = 0; i < 15; i++) begin
            chk("t6_wdog_clr", m_err_o, 0);
            tick();
        end
        chk("t6_err_fresh", m_err_o, 4'b0001);
        set_m(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        tick();
        tick();
        ack_auto = 1'b1;

        // 5: reset on beat 3 of a master-1 burst while master 0 waits
        set_m(0, 1'b1, 1'b1, 1'b1, 26'h0000010, 32'h0BADF00D, 4'hF);
        set_m(1, 1'b1, 1'b1, 1'b1, 26'h0000020, 32'hCAFEBABE, 4'hF);
        tick();
        for (int b = 0; b < 3; b++) begin
            chk("t5_gnt",  gnt_o,   4'b0010);
            chk("t5_ack",  m_ack_o, 4'b0010);
            if (b < 2) tick();
        end
        RESETN = 1'b0;
        tick();
        chk("t5_gnt_rst", gnt_o,   0);
        chk("t5_s_cyc",   s_cyc_o, 0);
        chk("t5_s_stb",   s_stb_o, 0);
        chk("t5_s_we",    s_we_o,  0);
        chk("t5_s_adr",   s_adr_o, 0);
        chk("t5_ack_rst", m_ack_o, 0);
        chk("t5_err_rst", m_err_o, 0);
        RESETN = 1'b1;
        tick();
        chk("t5_first", gnt_o, 4'b0001);
        m_cyc = '0;
        m_stb = '0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
